tlb_core: RTL

Fully-associative 16-entry LoongArch TLB. It is the responder for the TLB buses driven by write-back (TLBWR/TLBFILL write, TLBRD read), execute (TLBSRCH, INVTLB, load/store translation) and fetch (instruction translation). It holds the entry array, performs dual-port combinational lookup with 4 KB and 4 MB pages, and executes INVTLB bulk invalidation. All state updates land on the clock edge after the request.

---
 rtl/tlb_core_pkg.sv | 39 +++
 rtl/tlb_lookup.sv | 47 ++++
 rtl/tlb_core.sv | 102 ++++++++++
 3 files changed

// File: rtl/tlb_core_pkg.sv
// tlb_core_pkg: TLB geometry, page sizes, INVTLB op codes and the entry layout
package tlb_core_pkg;
  localparam int TLBNUM = 16;
  localparam int IDX_W = $clog2(TLBNUM);
  localparam logic [5:0] PS_4K = 6'd12;
  localparam logic [5:0] PS_4M = 6'd21;
  typedef enum logic [4:0] {
    INV_ALL0       = 5'd0,
    INV_ALL1       = 5'd1,
    INV_G          = 5'd2,
    INV_NG         = 5'd3,
    INV_NG_ASID    = 5'd4,
    INV_NG_ASID_VA = 5'd5,
    INV_GA_VA      = 5'd6
  } invtlb_op_t;
  typedef struct packed {
    logic        e;
    logic [18:0] vppn;
    logic [5:0]  ps;
    logic [9:0]  asid;
    logic        g;
    logic [19:0] ppn0;
    logic [1:0]  plv0;
    logic [1:0]  mat0;
    logic        d0;
    logic        v0;
    logic [19:0] ppn1;
    logic [1:0]  plv1;
    logic [1:0]  mat1;
    logic        d1;
    logic        v1;
  } tlb_entry_t;
  localparam int TLB_TO_WS_BUS_WD = $bits(tlb_entry_t);
  localparam int WS_TO_TLB_BUS_WD = 1 + IDX_W + $bits(tlb_entry_t);
  // 4 MB pages compare only the bits above the 4 MB boundary
  function automatic logic vpn_match(input logic [5:0] ps, input logic [18:0] a, input logic [18:0] b);
    return ps == PS_4K ? a == b : a[18:9] == b[18:9];
  endfunction
endpackage

// File: rtl/tlb_lookup.sv
// tlb_lookup: combinational match vector, lowest-index priority pick and page field mux
module tlb_lookup
  import tlb_core_pkg::*;
(
  input  tlb_entry_t [TLBNUM-1:0] entries,
  input  logic [18:0]             vppn,
  input  logic                    va_bit12,
  input  logic [9:0]              asid,
  output logic                    found,
  output logic [IDX_W-1:0]        index,
  output logic [19:0]             ppn,
  output logic [5:0]              ps,
  output logic [1:0]              plv,
  output logic [1:0]              mat,
  output logic                    d,
  output logic                    v,
  output logic [TLBNUM-1:0]       vpn_hit,
  output logic [TLBNUM-1:0]       asid_hit
);
  logic [TLBNUM-1:0] hit;
  tlb_entry_t sel;
  logic odd;
  always_comb begin
    found = 1'b0;
    index = '0;
    vpn_hit = '0;
    asid_hit = '0;
    hit = '0;
    for (int i = TLBNUM - 1; i >= 0; i--) begin
      vpn_hit[i] = vpn_match(entries[i].ps, entries[i].vppn, vppn);
      asid_hit[i] = entries[i].asid == asid;
      hit[i] = entries[i].e && (entries[i].g || asid_hit[i]) && vpn_hit[i];
      if (hit[i]) begin
        found = 1'b1;
        index = IDX_W'(i);
      end
    end
  end
  assign sel = found ? entries[index] : '0;
  assign odd = sel.ps == PS_4K ? va_bit12 : vppn[8];
  assign ppn = odd ? sel.ppn1 : sel.ppn0;
  assign plv = odd ? sel.plv1 : sel.plv0;
  assign mat = odd ? sel.mat1 : sel.mat0;
  assign d   = odd ? sel.d1 : sel.d0;
  assign v   = odd ? sel.v1 : sel.v0;
  assign ps  = sel.ps;
endmodule

// File: rtl/tlb_core.sv
// tlb_core: 16-entry fully-associative TLB with two search ports, a read port, write and INVTLB
module tlb_core
  import tlb_core_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [18:0]       s0_vppn,
  input  logic              s0_va_bit12,
  input  logic [9:0]        s0_asid,
  output logic              s0_found,
  output logic [IDX_W-1:0]  s0_index,
  output logic [19:0]       s0_ppn,
  output logic [5:0]        s0_ps,
  output logic [1:0]        s0_plv,
  output logic [1:0]        s0_mat,
  output logic              s0_d,
  output logic              s0_v,
  input  logic [18:0]       s1_vppn,
  input  logic              s1_va_bit12,
  input  logic [9:0]        s1_asid,
  output logic              s1_found,
  output logic [IDX_W-1:0]  s1_index,
  output logic [19:0]       s1_ppn,
  output logic [5:0]        s1_ps,
  output logic [1:0]        s1_plv,
  output logic [1:0]        s1_mat,
  output logic              s1_d,
  output logic              s1_v,
  input  logic              invtlb_valid,
  input  logic [4:0]        invtlb_op,
  input  logic              we,
  input  logic [IDX_W-1:0]  w_index,
  input  logic              w_e,
  input  logic [18:0]       w_vppn,
  input  logic [5:0]        w_ps,
  input  logic [9:0]        w_asid,
  input  logic              w_g,
  input  logic [19:0]       w_ppn0,
  input  logic [1:0]        w_plv0,
  input  logic [1:0]        w_mat0,
  input  logic              w_d0,
  input  logic              w_v0,
  input  logic [19:0]       w_ppn1,
  input  logic [1:0]        w_plv1,
  input  logic [1:0]        w_mat1,
  input  logic              w_d1,
  input  logic              w_v1,
  input  logic [IDX_W-1:0]  r_index,
  output logic              r_e,
  output logic [18:0]       r_vppn,
  output logic [5:0]        r_ps,
  output logic [9:0]        r_asid,
  output logic              r_g,
  output logic [19:0]       r_ppn0,
  output logic [1:0]        r_plv0,
  output logic [1:0]        r_mat0,
  output logic              r_d0,
  output logic              r_v0,
  output logic [19:0]       r_ppn1,
  output logic [1:0]        r_plv1,
  output logic [1:0]        r_mat1,
  output logic              r_d1,
  output logic              r_v1
);
  tlb_entry_t [TLBNUM-1:0] tlb;
  tlb_entry_t w_entry, rd;
  logic [TLBNUM-1:0] vpn_hit, asid_hit, g, inv;
  tlb_lookup u_s0 (
    .entries(tlb), .vppn(s0_vppn), .va_bit12(s0_va_bit12), .asid(s0_asid),
    .found(s0_found), .index(s0_index), .ppn(s0_ppn), .ps(s0_ps),
    .plv(s0_plv), .mat(s0_mat), .d(s0_d), .v(s0_v),
    .vpn_hit(), .asid_hit()
  );
  tlb_lookup u_s1 (
    .entries(tlb), .vppn(s1_vppn), .va_bit12(s1_va_bit12), .asid(s1_asid),
    .found(s1_found), .index(s1_index), .ppn(s1_ppn), .ps(s1_ps),
    .plv(s1_plv), .mat(s1_mat), .d(s1_d), .v(s1_v),
    .vpn_hit(vpn_hit), .asid_hit(asid_hit)
  );
  assign w_entry = '{w_e, w_vppn, w_ps, w_asid, w_g, w_ppn0, w_plv0, w_mat0, w_d0, w_v0,
                     w_ppn1, w_plv1, w_mat1, w_d1, w_v1};
  always_comb begin
    g = '0;
    for (int i = 0; i < TLBNUM; i++) g[i] = tlb[i].g;
    inv = (invtlb_op == INV_ALL0 || invtlb_op == INV_ALL1) ? '1 :
          invtlb_op == INV_G          ? g :
          invtlb_op == INV_NG         ? ~g :
          invtlb_op == INV_NG_ASID    ? ~g & asid_hit :
          invtlb_op == INV_NG_ASID_VA ? ~g & asid_hit & vpn_hit :
          invtlb_op == INV_GA_VA      ? (g | asid_hit) & vpn_hit : '0;
  end
  // the write lands after the invalidation so it wins on w_index
  always_ff @(posedge clk or posedge reset)
    if (reset) tlb <= '0;
    else begin
      for (int i = 0; i < TLBNUM; i++) if (invtlb_valid && inv[i]) tlb[i].e <= 1'b0;
      if (we) tlb[w_index] <= w_entry;
    end
  assign rd = tlb[r_index];
  assign {r_e, r_vppn, r_ps, r_asid, r_g, r_ppn0, r_plv0, r_mat0, r_d0, r_v0,
          r_ppn1, r_plv1, r_mat1, r_d1, r_v1} = rd;
endmodule
